// File: rtl/pipeline_dram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pipeline_dram_arbiter                                             |
// | Shares one DRAM port between the fetch and MEM-stage data channels, with   |
// | one outstanding transaction, per-channel stalls and a watchdog abort.      |
// | Option : ARB_ROUND_ROBIN_EN (alternate grants on simultaneous requests)    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module pipeline_dram_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [2:0]        if_rd_ctrl,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [2:0]        dm_rd_ctrl,
  input  logic [2:0]        dm_wr_ctrl,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_rd_ctrl,
  output logic [2:0]        mem_wr_ctrl,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_DM = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [7:0]        tmo_cnt;
  logic              busy;
  logic              tmo_hit;
  logic              finish;
  logic              grant_dm;
  logic              grant_if;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [2:0]        lat_rd;
  logic [2:0]        lat_wr;
  logic [DATA_W-1:0] lat_wdata;

  // A channel whose done is pulsing still shows req that cycle; never re-grant it.
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  assign busy    = (state == S_BUSY_IF) | (state == S_BUSY_DM);
  assign tmo_hit = busy & ~mem_ack & (tmo_cnt == 8'(TIMEOUT_CYC - 1));
  assign finish  = busy & (mem_ack | tmo_hit);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm;

  assign grant_dm = dm_stall & (~if_stall | ~last_dm);

  // Only contested grants move the fairness pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_dm <= 1'b0;
    else if ((state == S_IDLE) && dm_stall && if_stall)
      last_dm <= grant_dm;
  end
`else
  assign grant_dm = dm_stall;
`endif
  assign grant_if = if_stall & ~grant_dm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_dm)
          state_nxt = S_BUSY_DM;
        else if (grant_if)
          state_nxt = S_BUSY_IF;
      end
      S_BUSY_IF, S_BUSY_DM: begin
        if (finish)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_rd_ctrl = 3'b000;
    mem_wr_ctrl = 3'b000;
    mem_wdata   = '0;
    if (busy) begin
      mem_req     = 1'b1;
      mem_we      = lat_we;
      mem_addr    = lat_addr;
      mem_rd_ctrl = lat_rd;
      mem_wr_ctrl = lat_wr;
      mem_wdata   = lat_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_rd      <= 3'b000;
      lat_wr      <= 3'b000;
      lat_wdata   <= '0;
      tmo_cnt     <= 8'd0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      if_rdata    <= 32'd0;
      dm_rdata    <= '0;
      arb_timeout <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (grant_dm) begin
          lat_we    <= dm_we;
          lat_addr  <= dm_addr;
          lat_rd    <= dm_rd_ctrl;
          lat_wr    <= dm_wr_ctrl;
          lat_wdata <= dm_wdata;
        end else if (grant_if) begin
          lat_we    <= 1'b0;
          lat_addr  <= if_addr;
          lat_rd    <= if_rd_ctrl;
          lat_wr    <= 3'b000;
          lat_wdata <= '0;
        end
      end

      tmo_cnt     <= (busy && !finish) ? tmo_cnt + 8'd1 : 8'd0;
      if_done     <= finish && (state == S_BUSY_IF);
      dm_done     <= finish && (state == S_BUSY_DM);
      arb_timeout <= arb_timeout | tmo_hit;

      // An aborted read returns zero; writes never disturb dm_rdata.
      if (finish && (state == S_BUSY_IF))
        if_rdata <= mem_ack ? mem_rdata[31:0] : 32'd0;
      if (finish && (state == S_BUSY_DM) && !lat_we)
        dm_rdata <= mem_ack ? mem_rdata : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_dram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pipeline_dram_arbiter                                          |
// | Directed and randomized transactions against a transaction-level model.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pipeline_dram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [2:0]  if_rd_ctrl;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [2:0]  dm_rd_ctrl;
  logic [2:0]  dm_wr_ctrl;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [2:0]  mem_rd_ctrl;
  logic [2:0]  mem_wr_ctrl;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        arb_timeout;

  pipeline_dram_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rd_ctrl(if_rd_ctrl),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_rd_ctrl(dm_rd_ctrl),
    .dm_wr_ctrl(dm_wr_ctrl), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rd_ctrl(mem_rd_ctrl), .mem_wr_ctrl(mem_wr_ctrl), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Model state: last captured data per channel and who won the last conflict.
  logic [31:0] exp_if;
  logic [63:0] exp_dm;
  bit          last_dm;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit dm_first();
`ifdef ARB_ROUND_ROBIN_EN
    return !last_dm;
`else
    return 1'b1;
`endif
  endfunction

  task automatic set_if();
    if_addr    = {32'h0, 32'h8000_0000 | ($urandom & 32'h00FF_FFFC)};
    if_rd_ctrl = 3'($urandom_range(0, 7));
  endtask

  task automatic set_dm();
    dm_we      = 1'($urandom_range(0, 1));
    dm_addr    = {32'h0, 32'h8000_0000 | ($urandom & 32'h00FF_FFF8)};
    dm_rd_ctrl = 3'($urandom_range(0, 7));
    dm_wr_ctrl = 3'($urandom_range(0, 7));
    dm_wdata   = {$urandom, $urandom};
  endtask

  task automatic check_fields(input bit ch);
    if (ch) begin
      check("dm_mem_we", mem_we, dm_we);
      check("dm_mem_addr", mem_addr, dm_addr);
      check("dm_mem_rd", mem_rd_ctrl, dm_rd_ctrl);
      check("dm_mem_wr", mem_wr_ctrl, dm_wr_ctrl);
      if (dm_we) check("dm_mem_wdata", mem_wdata, dm_wdata);
    end else begin
      check("if_mem_we", mem_we, 0);
      check("if_mem_addr", mem_addr, if_addr);
      check("if_mem_rd", mem_rd_ctrl, if_rd_ctrl);
      check("if_mem_wr", mem_wr_ctrl, 0);
    end
  endtask

  // Called on the negedge just after the winning request was driven (or after
  // the previous done pulse when this channel was waiting); leaves on a negedge.
  task automatic serve(input bit ch, input int dly, input logic [63:0] data,
                       input bit drop_early, input bit raise_other, input bit tail);
    int w;
    w = 0;
    @(negedge clk);
    while (mem_req !== 1'b1 && w < 6) begin
      @(negedge clk);
      w++;
    end
    check("grant_latency", 64'(w), 64'd0);
    check("grant_req", mem_req, 1);
    check("idle_if_done", if_done, 0);
    check("idle_dm_done", dm_done, 0);
    check_fields(ch);
    if (drop_early) begin
      if (ch) dm_req = 1'b0;
      else if_req = 1'b0;
    end
    if (raise_other) begin
      if (ch) begin set_if(); if_req = 1'b1; end
      else begin set_dm(); dm_req = 1'b1; end
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("hold_req", mem_req, 1);
      check_fields(ch);
      check("no_early_done", ch ? dm_done : if_done, 0);
      check("other_stall", ch ? if_stall : dm_stall, ch ? if_req : dm_req);
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (ch) begin
      if (!dm_we) exp_dm = data;
    end else begin
      exp_if = data[31:0];
    end
    check("done_pulse", ch ? dm_done : if_done, 1);
    check("done_other", ch ? if_done : dm_done, 0);
    check("if_rdata", if_rdata, exp_if);
    check("dm_rdata", dm_rdata, exp_dm);
    check("req_drop", mem_req, 0);
    check("stall_clear", ch ? dm_stall : if_stall, 0);
    if (ch) dm_req = 1'b0;
    else if_req = 1'b0;
    if (tail) begin
      @(negedge clk);
      check("done_once", ch ? dm_done : if_done, 0);
      check("idle_after", mem_req, 0);
    end
  endtask

  task automatic conflict(input int dly1, input int dly2);
    bit first;
    first   = dm_first();
    last_dm = first;
    serve(first, dly1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    serve(!first, dly2, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int cnt;
    int mode;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; if_rd_ctrl = 3'b000;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_rd_ctrl = 3'b000;
    dm_wr_ctrl = 3'b000; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    exp_if = '0; exp_dm = '0; last_dm = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_if_done", if_done, 0);
    check("rst_dm_done", dm_done, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_timeout", arb_timeout, 0);
    reset = 1'b0;

    // Single fetch, ack one cycle after mem_req rises.
    if_addr = 64'h8000_0000; if_rd_ctrl = 3'b101; if_req = 1'b1;
    serve(1'b0, 1, 64'h0000_0000_0000_0013, 1'b0, 1'b0, 1'b1);
    check("fetch_if_rdata", if_rdata, 32'h13);
    check("fetch_if_stall", if_stall, 0);

    // Two simultaneous conflicts: data read 0x8000_0100 vs fetch.
    for (int k = 0; k < 2; k++) begin
      set_if(); if_req = 1'b1;
      set_dm(); dm_we = 1'b0; dm_addr = 64'h8000_0100; dm_req = 1'b1;
      conflict(1, 0);
    end

    // Write with ack after 3 cycles; read data must not move.
    dm_we = 1'b1; dm_addr = 64'h8000_0010; dm_wdata = 64'hDEAD_BEEF;
    dm_wr_ctrl = 3'b011; dm_rd_ctrl = 3'b000; dm_req = 1'b1;
    serve(1'b1, 3, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b1);

    // Stray ack in idle.
    mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_if_done", if_done, 0);
    check("stray_dm_done", dm_done, 0);
    check("stray_if_rdata", if_rdata, exp_if);
    check("stray_dm_rdata", dm_rdata, exp_dm);
    check("stray_req", mem_req, 0);

    // Request arriving during a busy fetch waits; requester drop keeps the pulse.
    set_if(); if_req = 1'b1;
    serve(1'b0, 2, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    dm_we = 1'b0;
    serve(1'b1, 1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b1);

    // Watchdog abort of a data read with no ack.
    set_dm(); dm_we = 1'b0; dm_req = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (mem_req === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    exp_dm = '0;
    check("tmo_cycles", 64'(cnt), 64'd255);
    check("tmo_req", mem_req, 0);
    check("tmo_done", dm_done, 1);
    check("tmo_rdata", dm_rdata, 0);
    check("tmo_flag", arb_timeout, 1);
    dm_req = 1'b0;
    @(negedge clk);
    check("tmo_done_once", dm_done, 0);
    set_if(); if_req = 1'b1;
    serve(1'b0, 0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
    check("tmo_sticky", arb_timeout, 1);

    // Reset in the middle of a fetch.
    set_if(); if_req = 1'b1;
    @(negedge clk);
    check("pre_rst_req", mem_req, 1);
    #1 reset = 1'b1;
    #1 check("rst_async_req", mem_req, 0);
    exp_if = '0; exp_dm = '0; last_dm = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_no_done", if_done, 0);
    check("rst_clear_tmo", arb_timeout, 0);
    check("rst_clear_rdata", if_rdata, 0);
    set_if(); if_req = 1'b1;
    serve(1'b0, 1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);

    // Randomized mix of single and conflicting requests.
    for (int i = 0; i < 16; i++) begin
      mode = $urandom_range(0, 2);
      if (mode != 1) begin set_if(); if_req = 1'b1; end
      if (mode != 0) begin set_dm(); dm_req = 1'b1; end
      if (mode == 2)
        conflict($urandom_range(0, 3), $urandom_range(0, 3));
      else
        serve(mode == 1, $urandom_range(0, 3), {$urandom, $urandom},
              1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
